// File: rtl/iomem_sample_fifo.sv
// Memory-mapped audio sample FIFO on the iomem bus.
// Firmware pushes samples; sample_tick pops them toward the codec.
module iomem_sample_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          DEPTH     = 16,
    parameter int          SAMPLE_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    input  logic                sample_tick,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                enable_q, enable_d, irq_en_q, irq_en_d;
    logic [7:0]          thresh_q, thresh_d;
    logic                underrun_q, underrun_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
    logic                sample_valid_q, sample_valid_d;
    logic                irq_q, irq_d;

    logic       sel, is_wr, full, empty, stall, fire;
    logic       push, flush, clr_udr, pop_req, pop;
    logic [1:0] off;
    logic [7:0] level8;
    logic       unused;

    assign unused = ^{iomem_addr[1:0], iomem_wdata};

    always_comb begin
        sel     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
        is_wr   = |iomem_wstrb;
        off     = iomem_addr[3:2];
        level8  = 8'(level_q);
        full    = (level_q == LW'(DEPTH));
        empty   = (level_q == '0);
        // A DATA write into a full FIFO waits here instead of dropping data.
        stall   = sel && is_wr && (off == 2'd0) && full;
        fire    = sel && !ready_q && !stall;
        push    = fire && is_wr && (off == 2'd0);
        flush   = fire && is_wr && (off == 2'd3) && iomem_wdata[1];
        clr_udr = fire && is_wr && (off == 2'd3) && iomem_wdata[0];
        pop_req = sample_tick && enable_q;
        pop     = pop_req && !empty && !flush;
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q + AW'(push);
        rd_ptr_d       = flush ? wr_ptr_q : rd_ptr_q + AW'(pop);
        level_d        = flush ? '0 : level_q + LW'(push) - LW'(pop);
        enable_d       = enable_q;
        irq_en_d       = irq_en_q;
        thresh_d       = thresh_q;
        underrun_d     = underrun_q;
        ready_d        = fire;
        rdata_d        = '0;
        sample_out_d   = sample_out_q;
        sample_valid_d = pop_req;
        irq_d          = enable_q && irq_en_q && (level8 <= thresh_q);

        if (fire && is_wr && (off == 2'd2)) begin
            enable_d = iomem_wdata[0];
            irq_en_d = iomem_wdata[1];
            thresh_d = iomem_wdata[15:8];
        end
        if (clr_udr)
            underrun_d = 1'b0;
        if (pop_req) begin
            sample_out_d = pop ? mem_q[rd_ptr_q] : '0;
            if (empty && !flush)
                underrun_d = 1'b1;
        end
        if (fire && !is_wr) begin
            case (off)
                2'd0:    rdata_d = 32'(sample_out_q);
                2'd1:    rdata_d = {21'd0, underrun_q, full, empty, level8};
                2'd2:    rdata_d = {16'd0, thresh_q, 6'd0, irq_en_q, enable_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            enable_q       <= 1'b0;
            irq_en_q       <= 1'b0;
            thresh_q       <= 8'(DEPTH / 2);
            underrun_q     <= 1'b0;
            ready_q        <= 1'b0;
            rdata_q        <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            enable_q       <= enable_d;
            irq_en_q       <= irq_en_d;
            thresh_q       <= thresh_d;
            underrun_q     <= underrun_d;
            ready_q        <= ready_d;
            rdata_q        <= rdata_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            irq_q          <= irq_d;
        end
    end

    // Storage needs no reset; only slots below level are ever read.
    always_ff @(posedge clk) begin
        if (resetn && push)
            mem_q[wr_ptr_q] <= iomem_wdata[SAMPLE_W-1:0];
    end

    assign iomem_ready  = ready_q;
    assign iomem_rdata  = rdata_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_iomem_sample_fifo.sv
// Directed bench for iomem_sample_fifo with a sample scoreboard queue.
module tb_iomem_sample_fifo;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_CLR  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        sample_tick;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    logic [15:0] last_out;
    logic [31:0] rd;
    int cyc;
    logic seen;

    iomem_sample_fifo dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .sample_tick(sample_tick), .sample_out(sample_out),
        .sample_valid(sample_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] r,
                       output int c);
        logic got;
        got = 1'b0;
        r = '0;
        c = 0;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        iomem_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            c++;
            if (iomem_ready) begin
                r = iomem_rdata;
                got = 1'b1;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (!got)
            chk("bus_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int c;
        bus(a, 4'hF, d, r, c);
    endtask

    task automatic push(input logic [15:0] v);
        wr(A_DATA, {16'd0, v});
        sb.push_back(v);
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a,
                         input logic [31:0] exp);
        logic [31:0] r;
        int c;
        bus(a, 4'h0, 32'd0, r, c);
        chk(tag, r, exp);
    endtask

    task automatic tick(input string tag);
        logic [15:0] exp;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        exp = (sb.size() > 0) ? sb.pop_front() : 16'd0;
        last_out = exp;
        chk({tag, "_valid"}, {31'd0, sample_valid}, 32'd1);
        chk({tag, "_out"}, {16'd0, sample_out}, {16'd0, exp});
        step();
        chk({tag, "_pulse"}, {31'd0, sample_valid}, 32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        sample_tick = 1'b0;
        last_out    = '0;
        step();
        step();
        chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_sout", {16'd0, sample_out}, 32'd0);
        chk("rst_svalid", {31'd0, sample_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        step();

        bus(A_STAT, 4'h0, 32'd0, rd, cyc);
        chk("stat_latency", cyc, 32'd1);
        chk("stat_reset", rd, 32'h0000_0100);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        rdchk("ctrl_reset", A_CTRL, 32'h0000_0800);

        wr(A_CTRL, 32'h0000_0801);
        rdchk("ctrl_rb", A_CTRL, 32'h0000_0801);
        push(16'h1234);
        push(16'h5678);
        tick("pop1");
        tick("pop2");
        rdchk("stat_drained", A_STAT, 32'h0000_0100);
        rdchk("data_rd", A_DATA, 32'h0000_5678);

        for (int i = 0; i < 16; i++)
            push(16'hA000 + 16'(i));
        rdchk("stat_full", A_STAT, 32'h0000_0210);
        iomem_addr  = A_DATA;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h0000_BEEF;
        iomem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", {31'd0, iomem_ready}, 32'd0);
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("stall_pop_v", {31'd0, sample_valid}, 32'd1);
        chk("stall_pop", {16'd0, sample_out}, {16'd0, sb.pop_front()});
        chk("stall_hold", {31'd0, iomem_ready}, 32'd0);
        step();
        chk("stall_release", {31'd0, iomem_ready}, 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        sb.push_back(16'hBEEF);
        step();
        chk("stall_once", {31'd0, iomem_ready}, 32'd0);
        rdchk("stat_full2", A_STAT, 32'h0000_0210);
        for (int i = 0; i < 16; i++)
            tick("wrap");
        rdchk("stat_empty", A_STAT, 32'h0000_0100);

        wr(A_CTRL, 32'h0000_0403);
        for (int i = 0; i < 6; i++)
            push(16'h0100 + 16'(i));
        step();
        chk("irq_lvl6", {31'd0, irq}, 32'd0);
        tick("irqpop");
        chk("irq_lvl5", {31'd0, irq}, 32'd0);
        tick("irqpop");
        chk("irq_lvl4", {31'd0, irq}, 32'd1);
        push(16'h0777);
        step();
        chk("irq_clear", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 5; i++)
            tick("irqdrain");

        wr(A_CTRL, 32'h0000_0000);
        push(16'h0999);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        chk("dis_valid", {31'd0, sample_valid}, 32'd0);
        chk("dis_hold", {16'd0, sample_out}, {16'd0, last_out});
        rdchk("dis_level", A_STAT, 32'h0000_0001);

        wr(A_CTRL, 32'h0000_0001);
        tick("deq");
        tick("underrun");
        rdchk("stat_udr", A_STAT, 32'h0000_0500);
        wr(A_CLR, 32'h0000_0001);
        rdchk("stat_udr_clr", A_STAT, 32'h0000_0100);
        rdchk("clr_rd0", A_CLR, 32'h0000_0000);

        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        rdchk("stat_lvl3", A_STAT, 32'h0000_0003);
        wr(A_CLR, 32'h0000_0002);
        sb.delete();
        rdchk("stat_flush", A_STAT, 32'h0000_0100);

        iomem_addr  = BASE + 32'h10;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (iomem_ready)
                seen = 1'b1;
        end
        iomem_valid = 1'b0;
        chk("out_of_window", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 16; i++)
            push(16'hC000 + 16'(i));
        iomem_addr  = A_DATA;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h0000_DEAD;
        iomem_valid = 1'b1;
        step();
        step();
        resetn = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (iomem_ready)
                seen = 1'b1;
        end
        resetn = 1'b1;
        step();
        if (iomem_ready)
            seen = 1'b1;
        chk("rst_stall_ready", {31'd0, seen}, 32'd0);
        sb.delete();
        rdchk("rst_stall_lvl", A_STAT, 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iomem_sample_fifo.md
Name: iomem_sample_fifo

Overview:
- Memory-mapped responder on the SoC iomem bus: the far end of the CPU's iomem initiator port.
- Firmware writes audio samples into a FIFO.
- The block pops one sample per sample_tick toward the codec datapath.
- It raises a level-sensitive refill interrupt, wired to irq_5, when the FIFO level drops to a programmable threshold.

Parameters:
- BASE_ADDR, 32'h0300_0000, register window base; 16-byte window, decode on iomem_addr[31:4].
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SAMPLE_W, 16, sample width in bits, at most 32.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- iomem_valid  in  1  initiator request; held until ready
- iomem_ready  out  1  responder completion pulse
- iomem_wstrb  in  4  byte strobes; nonzero = write, zero = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- sample_tick  in  1  one-cycle sample-rate strobe
- sample_out  out  SAMPLE_W  current output sample
- sample_valid  out  1  one-cycle pulse: sample_out updated
- irq  out  1  refill request, level

Behaviour:
- Reset (resetn=0 at a clk edge):
  - FIFO emptied, level=0.
  - CTRL=0, THRESH=DEPTH/2, underrun=0.
  - iomem_ready=0, iomem_rdata=0, sample_out=0, sample_valid=0, irq=0.
- Reset asserted mid-transaction: any pending access is dropped, with no ready pulse.
- Select: sel = iomem_valid && iomem_addr[31:4]==BASE_ADDR[31:4].
  - Outside the window the block never asserts ready.
- Handshake:
  - iomem_ready is registered.
  - ready <= sel && !ready && !stall.
  - Exactly one cycle high per access; latency 1 cycle after valid when not stalled.
  - The register side effect occurs on the cycle ready is driven high, exactly once per access.
  - rdata is registered with ready, and is 0 when ready=0.
- Register map (offset = iomem_addr[3:2]):
  - 0x0 DATA: write pushes wdata[SAMPLE_W-1:0]; read returns sample_out zero-extended.
  - 0x4 STATUS (RO): [7:0] level, [8] empty, [9] full, [10] underrun sticky.
  - 0x8 CTRL (RW): [0] enable, [1] irq_en, [15:8] THRESH.
  - 0xC CLEAR (WO): write with wdata[0]=1 clears underrun; wdata[1]=1 flushes the FIFO (level=0). Reads return 0.
  - Writes to RO offsets are ignored but still acknowledged.
- Full backpressure:
  - A DATA write while full sets stall=1; ready is held low until full deasserts.
  - Then the push and ready happen in the same cycle. No data is lost.
  - A flush cannot occur while a DATA write is stalled; the bus is single-master.
- Pop:
  - Condition: sample_tick && enable.
  - If not empty: sample_out <= head, pointer advances, sample_valid=1 next cycle.
  - If empty: sample_out <= 0, underrun <= 1, sample_valid=1.
  - sample_tick with enable=0: no pop, no pulse, sample_out holds.
- Simultaneous push and pop in one cycle: both occur and level is unchanged.
- Full flag: computed from the registered level, so a push when full waits one cycle even with a concurrent pop.
- Flush concurrent with a pop: the flush wins, and the pop outputs 0 without setting underrun.
- Pointers: log2(DEPTH) bits, natural wrap. Level is log2(DEPTH)+1 bits and saturates at DEPTH by construction.
- irq (registered): irq <= enable && irq_en && (level <= THRESH). Clears automatically once level exceeds THRESH.
- Storage: a register array or inferred RAM, with no read-during-write hazard visible at sample_out.

Test Plan:
- Reset, then read 0x0300_0004 → ready exactly 1 cycle after valid; rdata=0x0000_0100 (empty, level 0); irq=0.
- Write CTRL=0x0000_0801 (enable, THRESH=8); push 0x1234,0x5678; pulse sample_tick twice → sample_out 0x1234 then 0x5678, each with a one-cycle sample_valid; STATUS level returns to 0.
- Push 16 samples; 17th DATA write → ready stays low; pulse sample_tick → ready rises the cycle after the pop completes; STATUS=0x0000_0210 (full, level 16); FIFO order preserved across the wrap.
- Enable irq_en, THRESH=4, level 6 → irq=0; pop twice → irq=1 on the cycle after level reaches 4; push one → irq=0.
- sample_tick on empty FIFO → sample_out=0, STATUS bit10=1; write CLEAR=1 → bit10=0.
- Access 0x0300_0010 (outside window) → iomem_ready never asserts over 10 cycles; resetn low during a stalled DATA write → ready stays 0, level=0 after reset.
